// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP32 field widths, operand classes and special-value helpers
// for the sequencers that wrap the pipelined FPU datapaths.
package fpu_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_class_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} div_state_e;
  function automatic logic [31:0] fp_signed_special(input logic sign, input logic inf);
    return {sign, {EXP_W{inf}}, {FRAC_W{1'b0}}};
  endfunction
endpackage

// File: rtl/fpu_classify.sv
// fpu_classify: splits an FP32 word into class, sign and signalling-NaN flag;
// denormals are reported as zero (flush-to-zero on inputs).
module fpu_classify
  import fpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_word,
  output fp_class_e       o_class,
  output logic            o_sign,
  output logic            o_snan
);
  logic [EXP_W-1:0]  w_exp;
  logic [FRAC_W-1:0] w_frac;
  assign w_exp   = i_word[XLEN-2 -: EXP_W];
  assign w_frac  = i_word[FRAC_W-1:0];
  assign o_sign  = i_word[XLEN-1];
  assign o_class = (w_exp == '0) ? CLS_ZERO :
                   (w_exp != '1) ? CLS_NORM :
                   (w_frac == '0) ? CLS_INF : CLS_NAN;
  assign o_snan  = (w_exp == '1) && (w_frac != '0) && !w_frac[FRAC_W-1];
endmodule

// File: rtl/fpu_div_seq.sv
// fpu_div_seq: one-at-a-time FP32 divide sequencer; resolves special operands
// locally and otherwise waits DIV_LATENCY cycles on the reciprocal datapath.
module fpu_div_seq
  import fpu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DIV_LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  input  logic [XLEN-1:0] div_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_dz,
  output logic            out_nv
);
  div_state_e      r_state, w_next;
  logic [3:0]      r_cnt;
  logic [XLEN-1:0] r_div_a, r_div_b, r_res;
  logic            r_dz, r_nv;
  fp_class_e       w_cls_a, w_cls_b;
  logic            w_sign_a, w_sign_b, w_snan_a, w_snan_b, w_s, w_q_s, w_special;
  logic [XLEN-1:0] w_sp_res, w_q;
  logic            w_sp_dz, w_sp_nv;

  fpu_classify #(.XLEN(XLEN)) u_cls_a (.i_word(in_a), .o_class(w_cls_a), .o_sign(w_sign_a), .o_snan(w_snan_a));
  fpu_classify #(.XLEN(XLEN)) u_cls_b (.i_word(in_b), .o_class(w_cls_b), .o_sign(w_sign_b), .o_snan(w_snan_b));

  assign w_s       = w_sign_a ^ w_sign_b;
  assign w_special = (w_cls_a != CLS_NORM) || (w_cls_b != CLS_NORM);

  // Ordered by IEEE priority: NaN, invalid, divide-by-zero, inf, zero.
  always_comb begin
    w_sp_res = fp_signed_special(w_s, 1'b0);
    w_sp_dz  = 1'b0;
    w_sp_nv  = 1'b0;
    if (w_cls_a == CLS_NAN || w_cls_b == CLS_NAN) begin
      w_sp_res = QNAN;
      w_sp_nv  = w_snan_a | w_snan_b;
    end else if ((w_cls_a == CLS_INF && w_cls_b == CLS_INF) || (w_cls_a == CLS_ZERO && w_cls_b == CLS_ZERO)) begin
      w_sp_res = QNAN;
      w_sp_nv  = 1'b1;
    end else if (w_cls_a == CLS_NORM && w_cls_b == CLS_ZERO) begin
      w_sp_res = fp_signed_special(w_s, 1'b1);
      w_sp_dz  = 1'b1;
    end else if (w_cls_a == CLS_INF) begin
      w_sp_res = fp_signed_special(w_s, 1'b1);
    end
  end

  // Datapath quotient: sign forced from the held operands, underflow flushed.
  assign w_q_s = r_div_a[XLEN-1] ^ r_div_b[XLEN-1];
  assign w_q   = (div_result[XLEN-2 -: EXP_W] == '0) ? {w_q_s, {(XLEN-1){1'b0}}} :
                 ({w_q_s, {(XLEN-1){1'b0}}} | (div_result & {1'b0, {(XLEN-1){1'b1}}}));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = in_valid ? (w_special ? RESP : WAIT) : IDLE;
      WAIT:    w_next = (r_cnt == '0) ? RESP : WAIT;
      RESP:    w_next = out_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div_a <= '0;
      r_div_b <= '0;
      r_res   <= '0;
      r_dz    <= 1'b0;
      r_nv    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_div_a <= in_a;
        r_div_b <= in_b;
        r_cnt   <= 4'(DIV_LATENCY - 1);
        r_res   <= w_sp_res;
        r_dz    <= w_sp_dz;
        r_nv    <= w_sp_nv;
      end else if (r_state == WAIT) begin
        if (r_cnt == '0) begin
          r_res <= w_q;
          r_dz  <= 1'b0;
          r_nv  <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == RESP);
  assign div_a      = r_div_a;
  assign div_b      = r_div_b;
  assign out_result = r_res;
  assign out_dz     = r_dz;
  assign out_nv     = r_nv;
endmodule

// File: tb/tb_fpu_div_seq.sv
// tb_fpu_div_seq: scoreboard bench with a fixed-latency datapath model that
// only presents its quotient DL cycles after an operand pair is accepted.
module tb_fpu_div_seq;
  localparam int DL = 4;
  typedef struct packed {logic [31:0] res; logic dz; logic nv;} exp_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_dz, out_nv;
  logic [31:0] in_a, in_b, div_a, div_b, div_result, out_result;
  logic [31:0] model_q = 32'h0;
  logic hs = 1'b0;
  int age = 100;
  int passed = 0, total = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fpu_div_seq #(.XLEN(32), .DIV_LATENCY(DL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dz(out_dz), .out_nv(out_nv)
  );

  // Datapath model: garbage until the DL-th cycle after acceptance.
  always @(posedge clk) hs <= in_valid && in_ready;
  always @(negedge clk) begin
    age = hs ? 1 : (age < 100 ? age + 1 : age);
    div_result = (age >= DL) ? model_q : 32'hDEADBEEF;
  end

  task automatic wait_out(output int k);
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (out_result !== 32'h0) $display("FAIL reset_out_result got %h want 0", out_result); else passed++;
    total++; if ({out_dz, out_nv} !== 2'b00) $display("FAIL reset_flags got %b want 00", {out_dz, out_nv}); else passed++;
    total++; if ({div_a, div_b} !== 64'h0) $display("FAIL reset_div got %h/%h want 0/0", div_a, div_b); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q, input logic [31:0] want);
    exp_t e;
    int k;
    model_q = q;
    sb.push_back('{want, 1'b0, 1'b0});
    in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      total++; if (div_a !== a || div_b !== b) $display("FAIL norm_div_hold got %h/%h want %h/%h", div_a, div_b, a, b); else passed++;
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    total++; if (k + 1 !== DL + 1) $display("FAIL norm_latency %h/%h got %0d want %0d", a, b, k + 1, DL + 1); else passed++;
    total++; if (out_result !== e.res) $display("FAIL norm_result %h/%h got %h want %h", a, b, out_result, e.res); else passed++;
    total++; if ({out_dz, out_nv} !== {e.dz, e.nv}) $display("FAIL norm_flags %h/%h got %b want %b", a, b, {out_dz, out_nv}, {e.dz, e.nv}); else passed++;
    @(negedge clk);
  endtask

  task automatic test_special(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want, input logic dz, input logic nv);
    exp_t e;
    int k;
    model_q = 32'h12345678;
    sb.push_back('{want, dz, nv});
    in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(k);
    e = sb.pop_front();
    total++; if (k + 1 !== 1) $display("FAIL spec_latency %h/%h got %0d want 1", a, b, k + 1); else passed++;
    total++; if (out_result !== e.res) $display("FAIL spec_result %h/%h got %h want %h", a, b, out_result, e.res); else passed++;
    total++; if ({out_dz, out_nv} !== {e.dz, e.nv}) $display("FAIL spec_flags %h/%h got %b want %b", a, b, {out_dz, out_nv}, {e.dz, e.nv}); else passed++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int k;
    out_ready = 1'b0;
    sb.push_back('{32'hFF800000, 1'b1, 1'b0});
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h80000000;
    @(posedge clk);
    @(negedge clk);
    in_a = 32'h40C00000; in_b = 32'h40000000;
    model_q = 32'h40400000;
    wait_out(k);
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL bp_handshake cyc %0d got v=%b r=%b want v=1 r=0", i, out_valid, in_ready); else passed++;
      total++; if ({out_result, out_dz, out_nv} !== {e.res, e.dz, e.nv}) $display("FAIL bp_hold cyc %0d got %h %b%b want %h %b%b", i, out_result, out_dz, out_nv, e.res, e.dz, e.nv); else passed++;
      total++; if (div_a !== 32'h3F800000) $display("FAIL bp_no_capture cyc %0d got %h want 3f800000", i, div_a); else passed++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    sb.push_back('{32'h40400000, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); else passed++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(k);
    e = sb.pop_front();
    total++; if (k + 1 !== DL + 1) $display("FAIL bp_next_latency got %0d want %0d", k + 1, DL + 1); else passed++;
    total++; if (out_result !== e.res) $display("FAIL bp_next_result got %h want %h", out_result, e.res); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    model_q = 32'h40400000;
    in_valid = 1'b1; in_a = 32'h40C00000; in_b = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL abort_handshake got r=%b v=%b want r=1 v=0", in_ready, out_valid); else passed++;
    total++; if ({div_a, div_b} !== 64'h0) $display("FAIL abort_div got %h/%h want 0/0", div_a, div_b); else passed++;
    total++; if ({out_result, out_dz, out_nv} !== 34'h0) $display("FAIL abort_out got %h %b%b want 0", out_result, out_dz, out_nv); else passed++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) $display("FAIL abort_no_valid got %0d cycles want 0", seen); else passed++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0;
    test_reset();
    test_normal(32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000);
    test_normal(32'hC0C00000, 32'h40000000, 32'h40400000, 32'hC0400000);
    test_normal(32'h00800000, 32'h7F000000, 32'h00400000, 32'h00000000);
    test_special(32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1, 1'b0);
    test_special(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1);
    test_special(32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1);
    test_special(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0);
    test_special(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b1);
    test_special(32'hFF800000, 32'h00000000, 32'hFF800000, 1'b0, 1'b0);
    test_special(32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0);
    test_special(32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0);
    test_backpressure();
    test_reset_mid_wait();
    test_normal(32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
